// File: rtl/dequantize.sv
// dequantize: expands a burst of VEC_LEN signed int8 values to 32-bit signed
// fixed point as (q - zero_point) * SCALE, through a two-stage pipeline.
//
// Ports
//   clk_i      clock, rising edge
//   rstn_i     asynchronous active-low reset
//   i_start    burst start pulse, accepted only in IDLE (latches zp_i)
//   i_dq_en    input beat valid; din_i is taken when high in RUN
//   din_i      signed int8 quantized value
//   zp_i       signed zero point
//   o_dqout    signed dequantized value, 0 when o_dqvalid is low
//   o_dqvalid  o_dqout valid this cycle
//   done_o     pulse alongside the last o_dqvalid of a burst
//   o_busy     high in RUN and DRAIN
//   o_err      sticky protocol error, cleared by reset or an accepted i_start
//
// state | meaning
// IDLE  | waiting for i_start
// RUN   | accepting beats until VEC_LEN have been taken
// DRAIN | last beat is moving through the two pipeline stages (2 cycles)
module dequantize #(
    parameter int unsigned SCALE   = 2408,
    parameter int unsigned VEC_LEN = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               i_start,
    input  logic               i_dq_en,
    input  logic signed [7:0]  din_i,
    input  logic signed [7:0]  zp_i,
    output logic signed [31:0] o_dqout,
    output logic               o_dqvalid,
    output logic               done_o,
    output logic               o_busy,
    output logic               o_err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [7:0]         LAST_IDX = 8'(VEC_LEN - 1);
    localparam logic signed [31:0] SCALE_S  = 32'(SCALE);

    state_t state_q, state_d;

    logic [7:0]         cnt_q;
    logic signed [7:0]  zp_q;
    logic               err_q;

    logic               s1_valid_q, s1_last_q;
    logic signed [8:0]  s1_diff_q;
    logic               s2_valid_q, s2_last_q;
    logic signed [31:0] s2_data_q;

    logic               start_acc, beat_acc, last_beat, err_ev, burst_done;
    logic signed [8:0]  diff_c;
    logic signed [31:0] diff_w, prod_c;

    assign start_acc  = i_start && (state_q == IDLE);
    assign beat_acc   = i_dq_en && (state_q == RUN);
    assign last_beat  = beat_acc && (cnt_q == LAST_IDX);
    assign burst_done = s2_valid_q && s2_last_q;

    // A beat arriving together with an accepted start is silently ignored.
    assign err_ev = (i_start && (state_q != IDLE))
                 || (i_dq_en && (((state_q == IDLE) && !i_start) || (state_q == DRAIN)));

    // Sign-extend both operands to 9 bits so the full int8 range difference fits.
    assign diff_c = {din_i[7], din_i} - {zp_q[7], zp_q};
    assign diff_w = 32'(s1_diff_q);
    assign prod_c = diff_w * SCALE_S;

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_acc)  state_d = RUN;
            RUN:     if (last_beat)  state_d = DRAIN;
            DRAIN:   if (burst_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_busy = (state_q == RUN) || (state_q == DRAIN);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
            zp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_d == IDLE)   cnt_q <= '0;
            else if (beat_acc)     cnt_q <= cnt_q + 8'd1;

            if (start_acc)         zp_q <= zp_i;

            if (start_acc)         err_q <= 1'b0;
            else if (err_ev)       err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_diff_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= beat_acc;
            s1_last_q  <= last_beat;
            s1_diff_q  <= beat_acc ? diff_c : 9'sd0;
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_valid_q && s1_last_q;
            // Held at zero between valid beats so o_dqout reads 0 when idle.
            s2_data_q  <= s1_valid_q ? prod_c : 32'sd0;
        end
    end

    assign o_dqout   = s2_data_q;
    assign o_dqvalid = s2_valid_q;
    assign done_o    = burst_done;
    assign o_err     = err_q;

endmodule

// File: tb/tb_dequantize.sv
module tb_dequantize;

    logic               clk_i = 1'b0;
    logic               rstn_i = 1'b0;
    logic               i_start = 1'b0;
    logic               i_dq_en = 1'b0;
    logic signed [7:0]  din_i = '0;
    logic signed [7:0]  zp_i = '0;
    logic signed [31:0] o_dqout;
    logic               o_dqvalid, done_o, o_busy, o_err;

    dequantize #(.SCALE(2408), .VEC_LEN(8)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .i_start(i_start), .i_dq_en(i_dq_en),
        .din_i(din_i), .zp_i(zp_i), .o_dqout(o_dqout), .o_dqvalid(o_dqvalid),
        .done_o(done_o), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic signed [31:0] v;
        logic               last;
        int                 cyc;
    } exp_t;
    exp_t q[$];

    int n_vec = 0;
    int n_fail = 0;

    // Monitor: compares every presented output against the scoreboard head.
    always @(negedge clk_i) begin
        if (o_dqvalid) begin
            n_vec++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got %0d done=%0d at cyc %0d, expected none", o_dqout, done_o, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (o_dqout !== e.v || done_o !== e.last || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL dqout: got %0d done=%0d cyc=%0d, expected %0d done=%0d cyc=%0d",
                             o_dqout, done_o, cyc, e.v, e.last, e.cyc);
                end
            end
        end else if (rstn_i && (o_dqout !== 32'sd0 || done_o !== 1'b0)) begin
            n_vec++;
            n_fail++;
            $display("FAIL idle_out: got dqout=%0d done=%0d, expected 0 0", o_dqout, done_o);
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic start(input logic signed [7:0] z);
        i_start = 1'b1;
        zp_i    = z;
        step();
        i_start = 1'b0;
    endtask

    task automatic beat(input logic signed [7:0] d, input logic signed [31:0] ev, input logic last);
        i_dq_en = 1'b1;
        din_i   = d;
        q.push_back('{ev, last, cyc + 2});
        step();
        i_dq_en = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (q.size() == 0) break;
            step();
        end
        if (q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: %0d outputs still pending, expected 0", q.size());
            q.delete();
        end
    endtask

    typedef logic signed [7:0]  din_arr_t [8];
    typedef logic signed [31:0] exp_arr_t [8];

    // gap: bubble between beats; mid: beat index carrying a stray i_start; poke: beat in DRAIN
    task automatic burst(input din_arr_t d, input exp_arr_t e, input bit gap, input int mid, input bit poke);
        for (int k = 0; k < 8; k++) begin
            if (k == mid) begin
                i_start = 1'b1;
                zp_i    = 8'sd100;
            end
            beat(d[k], e[k], k == 7);
            i_start = 1'b0;
            if (k == mid) check("err_start_in_run", 32'(o_err), 32'd1);
            if (gap && k < 7) step();
        end
        if (poke) begin
            i_dq_en = 1'b1;
            din_i   = 8'sd9;
            step();
            i_dq_en = 1'b0;
            check("err_beat_in_drain", 32'(o_err), 32'd1);
        end
        wait_drain();
        check("busy_after_done", 32'(o_busy), 32'd0);
    endtask

    din_arr_t d1 = '{8'sd1, -8'sd1, 8'sd127, -8'sd128, 8'sd0, 8'sd2, -8'sd2, 8'sd5};
    exp_arr_t e1 = '{32'sd2408, -32'sd2408, 32'sd305816, -32'sd308224, 32'sd0, 32'sd4816, -32'sd4816, 32'sd12040};
    din_arr_t d2 = '{8'sd10, -8'sd128, 8'sd127, 8'sd0, -8'sd10, 8'sd20, -8'sd1, 8'sd50};
    exp_arr_t e2 = '{32'sd0, -32'sd332304, 32'sd281736, -32'sd24080, -32'sd48160, 32'sd24080, -32'sd26488, 32'sd96320};
    din_arr_t d3 = '{8'sd0, 8'sd1, -8'sd1, 8'sd100, -8'sd100, 8'sd127, -8'sd128, 8'sd7};
    exp_arr_t e3 = '{32'sd7224, 32'sd9632, 32'sd4816, 32'sd248024, -32'sd233576, 32'sd313040, -32'sd301000, 32'sd24080};
    din_arr_t d4 = '{8'sd127, -8'sd128, 8'sd0, 8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5};
    exp_arr_t e4 = '{32'sd614040, 32'sd0, 32'sd308224, 32'sd310632, 32'sd313040, 32'sd315448, 32'sd317856, 32'sd320264};
    din_arr_t d6 = '{8'sd5, 8'sd6, 8'sd4, -8'sd128, 8'sd127, 8'sd0, -8'sd5, 8'sd15};
    exp_arr_t e6 = '{32'sd0, 32'sd2408, -32'sd2408, -32'sd320264, 32'sd293776, -32'sd12040, -32'sd24080, 32'sd24080};

    initial begin
        #1;
        check("rst_dqout", o_dqout, 32'd0);
        check("rst_valid", 32'(o_dqvalid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        step();
        step();
        rstn_i = 1'b1;
        step();

        // 1: zp=0 back-to-back
        start(8'sd0);
        check("busy_run", 32'(o_busy), 32'd1);
        burst(d1, e1, 1'b0, -1, 1'b0);

        // 2: zp=10
        start(8'sd10);
        burst(d2, e2, 1'b0, -1, 1'b0);

        // 3: gapped burst, zp=-3, then a beat during DRAIN
        start(-8'sd3);
        burst(d3, e3, 1'b1, -1, 1'b1);

        // 4: beat in IDLE sets error; start with beat clears it, beat ignored
        i_dq_en = 1'b1;
        din_i   = 8'sd3;
        step();
        i_dq_en = 1'b0;
        check("err_beat_in_idle", 32'(o_err), 32'd1);
        step();
        step();
        i_dq_en = 1'b1;
        start(-8'sd128);
        i_dq_en = 1'b0;
        check("err_cleared_by_start", 32'(o_err), 32'd0);
        burst(d4, e4, 1'b0, -1, 1'b0);

        // 5: reset after 4 accepted beats
        start(8'sd0);
        for (int k = 0; k < 4; k++) beat(d1[k], e1[k], 1'b0);
        rstn_i = 1'b0;
        q.delete();
        #1;
        check("abort_dqout", o_dqout, 32'd0);
        check("abort_valid", 32'(o_dqvalid), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        step();
        step();
        rstn_i = 1'b1;
        step();
        start(8'sd0);
        burst(d1, e1, 1'b0, -1, 1'b0);

        // 6: stray start mid-burst with a different zp
        start(8'sd5);
        burst(d6, e6, 1'b0, 3, 1'b0);
        check("err_sticky", 32'(o_err), 32'd1);

        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule
